i_cache_dm: RTL and testbench

Parametrised direct-mapped instruction cache between the instruction fetcher and the byte-wide memory controller. It serves 32-bit instruction fetches from a tag/data array of 2^INDEX_BITS lines of 2^WORD_BITS words each. On a miss it refills the whole line byte-by-byte over an 8-bit memory port, then returns the requested word. It adds line-granular storage, a refill FSM, tag compare and a global flush.

---
 rtl/i_cache_pkg.sv | 35 +++
 rtl/i_cache_refill.sv | 98 +++++++++
 rtl/i_cache_dm.sv | 218 +++++++++++++++++++++
 tb/tb_i_cache_dm.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i_cache_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i_cache_pkg
// Purpose  : Shared types and geometry helpers for the direct-mapped
//            instruction cache (state encoding, tag/line size functions).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package i_cache_pkg;

    // Cache controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Tag width: address bits left over after index, word and byte offset.
    function automatic int tag_width(input int aw, input int ib, input int wb);
        return aw - ib - wb - 2;
    endfunction

    // Bytes per line: 4 bytes per 32-bit word.
    function automatic int line_bytes(input int wb);
        return 4 << wb;
    endfunction

    // Bits per line.
    function automatic int line_bits(input int wb);
        return 32 << wb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i_cache_refill.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i_cache_refill
// Purpose  : Byte-serial line refill engine. Walks mem_addr across one
//            aligned line, assembles the returned bytes into a line buffer
//            and pulses o_done on the cycle the last byte is accepted.
// Ports    : clk_in/rst_in/rdy_in  clock, sync active-low reset, pause
//            i_start, i_base        begin a refill at line base address
//            i_mem_valid/i_mem_data returned byte for the current address
//            o_mem_req/o_mem_addr   level request and byte address
//            o_line                 registered line buffer
//            o_line_next            line buffer including this cycle's byte
//            o_done                 last byte accepted this cycle
// Revision : 1.0 - initial release
// ============================================================================
module i_cache_refill
    import i_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int WORD_BITS  = 1
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               rdy_in,
    input  logic                               i_start,
    input  logic [ADDR_WIDTH-1:0]              i_base,
    input  logic                               i_mem_valid,
    input  logic [7:0]                         i_mem_data,
    output logic                               o_mem_req,
    output logic [ADDR_WIDTH-1:0]              o_mem_addr,
    output logic [line_bits(WORD_BITS)-1:0]    o_line,
    output logic [line_bits(WORD_BITS)-1:0]    o_line_next,
    output logic                               o_done
);

    localparam int c_LINE_B = line_bytes(WORD_BITS);
    localparam int c_LINE_W = line_bits(WORD_BITS);
    localparam int c_OFF_W  = WORD_BITS + 2;

    logic                  mem_req_q,  mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [c_LINE_W-1:0]   line_q,     line_d;

    logic [c_OFF_W-1:0]    w_byte_sel;
    logic                  w_take;

    // The low address bits double as the byte counter: lines are aligned,
    // so the refill is finished when they reach the last byte of the line.
    assign w_byte_sel = mem_addr_q[c_OFF_W-1:0];
    assign w_take     = rdy_in && mem_req_q && i_mem_valid;
    assign o_done     = w_take && (w_byte_sel == c_OFF_W'(c_LINE_B - 1));

    always_comb begin
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        line_d     = line_q;
        for (int b = 0; b < c_LINE_B; b++) begin
            if (w_take && (w_byte_sel == c_OFF_W'(b))) begin
                line_d[b*8 +: 8] = i_mem_data;
            end
        end
        if (rdy_in) begin
            if (i_start) begin
                mem_req_d  = 1'b1;
                mem_addr_d = i_base;
            end else if (w_take) begin
                mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                if (o_done) begin
                    mem_req_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Buffer contents are only consumed after a complete refill, so it
    // needs no reset.
    always_ff @(posedge clk_in) begin
        line_q <= line_d;
    end

    assign o_mem_req   = mem_req_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_line      = line_q;
    assign o_line_next = line_d;

endmodule
`default_nettype wire

// File: rtl/i_cache_dm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i_cache_dm
// Purpose  : Direct-mapped instruction cache. Serves 32-bit fetches from
//            2^INDEX_BITS lines of 2^WORD_BITS words; refills missing lines
//            byte-by-byte over an 8-bit memory port; supports global flush.
// Ports    : clk_in, rst_in (sync, active-low), rdy_in (pause)
//            flush                     invalidate all lines
//            fetch_req/fetch_addr      fetch request (taken when fetch_ready)
//            fetch_ready               high while idle
//            inst_valid/inst_out       one-cycle instruction result
//            mem_req/mem_addr          byte request to memory
//            mem_valid/mem_data        byte returned by memory
// Revision : 1.0 - initial release
// ============================================================================
module i_cache_dm
    import i_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int INDEX_BITS = 4,
    parameter int WORD_BITS  = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    output logic                  inst_valid,
    output logic [31:0]           inst_out,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [7:0]            mem_data
);

    localparam int c_TAG_W  = tag_width(ADDR_WIDTH, INDEX_BITS, WORD_BITS);
    localparam int c_LINE_W = line_bits(WORD_BITS);
    localparam int c_LINES  = 1 << INDEX_BITS;
    localparam int c_WORDS  = 1 << WORD_BITS;
    localparam int c_OFF_W  = WORD_BITS + 2;

    // Storage arrays: contents survive reset, only valid bits are cleared.
    logic [c_LINE_W-1:0]   data_q [c_LINES];
    logic [c_TAG_W-1:0]    tag_q  [c_LINES];
    logic [c_LINES-1:0]    valid_q, valid_d;

    state_e                state_q, state_d;
    logic                  cancel_q, cancel_d;
    logic                  inst_valid_q, inst_valid_d;
    logic [31:0]           inst_out_q, inst_out_d;
    logic                  fetch_ready_q, fetch_ready_d;
    logic [WORD_BITS-1:0]  req_word_q, req_word_d;
    logic [INDEX_BITS-1:0] req_index_q, req_index_d;
    logic [c_TAG_W-1:0]    req_tag_q, req_tag_d;

    logic [c_TAG_W-1:0]    w_fetch_tag;
    logic [INDEX_BITS-1:0] w_fetch_index;
    logic [WORD_BITS-1:0]  w_fetch_word;
    logic [ADDR_WIDTH-1:0] w_fetch_base;
    logic [c_LINE_W-1:0]   w_hit_line;
    logic [c_LINE_W-1:0]   w_line_buf;
    logic [c_LINE_W-1:0]   w_line_next;
    logic [31:0]           w_hit_word;
    logic [31:0]           w_buf_word;
    logic                  w_hit;
    logic                  w_start;
    logic                  w_done;
    logic                  w_line_we;
    logic                  unused_offset;

    assign w_fetch_tag   = fetch_addr[ADDR_WIDTH-1 -: c_TAG_W];
    assign w_fetch_index = fetch_addr[c_OFF_W +: INDEX_BITS];
    assign w_fetch_word  = fetch_addr[2 +: WORD_BITS];
    assign w_fetch_base  = {fetch_addr[ADDR_WIDTH-1:c_OFF_W], {c_OFF_W{1'b0}}};
    assign unused_offset = ^fetch_addr[1:0];

    // A simultaneous flush forces a miss so the fetch never returns data
    // from a line that is being invalidated in the same cycle.
    assign w_hit_line = data_q[w_fetch_index];
    assign w_hit      = valid_q[w_fetch_index]
                        && (tag_q[w_fetch_index] == w_fetch_tag)
                        && !flush;

    always_comb begin
        w_hit_word = '0;
        w_buf_word = '0;
        for (int w = 0; w < c_WORDS; w++) begin
            if (w_fetch_word == WORD_BITS'(w)) begin
                w_hit_word = w_hit_line[w*32 +: 32];
            end
            if (req_word_q == WORD_BITS'(w)) begin
                w_buf_word = w_line_buf[w*32 +: 32];
            end
        end
    end

    i_cache_refill #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_BITS  (WORD_BITS)
    ) u_refill (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .i_start     (w_start),
        .i_base      (w_fetch_base),
        .i_mem_valid (mem_valid),
        .i_mem_data  (mem_data),
        .o_mem_req   (mem_req),
        .o_mem_addr  (mem_addr),
        .o_line      (w_line_buf),
        .o_line_next (w_line_next),
        .o_done      (w_done)
    );

    always_comb begin
        state_d      = state_q;
        cancel_d     = cancel_q;
        inst_valid_d = inst_valid_q;
        inst_out_d   = inst_out_q;
        req_word_d   = req_word_q;
        req_index_d  = req_index_q;
        req_tag_d    = req_tag_q;
        valid_d      = valid_q;
        w_start      = 1'b0;
        w_line_we    = 1'b0;
        if (rdy_in) begin
            inst_valid_d = 1'b0;
            if (flush) begin
                valid_d = '0;
            end
            case (state_q)
                IDLE: begin
                    if (fetch_req) begin
                        if (w_hit) begin
                            inst_valid_d = 1'b1;
                            inst_out_d   = w_hit_word;
                        end else begin
                            req_word_d  = w_fetch_word;
                            req_index_d = w_fetch_index;
                            req_tag_d   = w_fetch_tag;
                            cancel_d    = 1'b0;
                            w_start     = 1'b1;
                            state_d     = REFILL;
                        end
                    end
                end
                REFILL: begin
                    // The refill always completes so memory sees a clean
                    // handshake; a flush only suppresses validation/response.
                    if (flush) begin
                        cancel_d = 1'b1;
                    end
                    if (w_done) begin
                        w_line_we = 1'b1;
                        if (!(cancel_q || flush)) begin
                            valid_d[req_index_q] = 1'b1;
                        end
                        state_d = RESP;
                    end
                end
                RESP: begin
                    if (!cancel_q) begin
                        inst_valid_d = 1'b1;
                        inst_out_d   = w_buf_word;
                    end
                    cancel_d = 1'b0;
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        fetch_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            cancel_q      <= 1'b0;
            inst_valid_q  <= 1'b0;
            inst_out_q    <= '0;
            fetch_ready_q <= 1'b1;
            valid_q       <= '0;
            req_word_q    <= '0;
            req_index_q   <= '0;
            req_tag_q     <= '0;
        end else begin
            state_q       <= state_d;
            cancel_q      <= cancel_d;
            inst_valid_q  <= inst_valid_d;
            inst_out_q    <= inst_out_d;
            fetch_ready_q <= fetch_ready_d;
            valid_q       <= valid_d;
            req_word_q    <= req_word_d;
            req_index_q   <= req_index_d;
            req_tag_q     <= req_tag_d;
        end
    end

    // Line write uses the buffer with the final byte merged in, since that
    // byte lands in the buffer on the same edge.
    always_ff @(posedge clk_in) begin
        if (rst_in && w_line_we) begin
            data_q[req_index_q] <= w_line_next;
            tag_q[req_index_q]  <= req_tag_q;
        end
    end

    assign fetch_ready = fetch_ready_q;
    assign inst_valid  = inst_valid_q;
    assign inst_out    = inst_out_q;

endmodule
`default_nettype wire

// File: tb/tb_i_cache_dm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i_cache_dm
// Purpose  : Self-checking bench for i_cache_dm. Directed scenarios plus
//            randomized fetches checked against a line-level cache model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i_cache_dm;

    localparam int AW = 17;
    localparam int IB = 4;
    localparam int WB = 1;
    localparam int NB = 4 << WB;
    localparam int NL = 1 << IB;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          flush;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_ready;
    logic          inst_valid;
    logic [31:0]   inst_out;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_valid;
    logic [7:0]    mem_data;

    i_cache_dm #(
        .ADDR_WIDTH (AW),
        .INDEX_BITS (IB),
        .WORD_BITS  (WB)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .flush       (flush),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .inst_valid  (inst_valid),
        .inst_out    (inst_out),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_data    (mem_data)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;
    bit hash_mode = 1'b0;
    bit mvalid [NL];
    int mtag   [NL];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory image: a pure function of the byte address.
    function automatic logic [7:0] memf(input logic [AW-1:0] a);
        if (hash_mode) return a[7:0] ^ a[16:9];
        return a[7:0];
    endfunction

    function automatic logic [31:0] word_of(input logic [AW-1:0] a);
        logic [AW-1:0] b;
        b = a & ~(AW'(3));
        return {memf(b + AW'(3)), memf(b + AW'(2)), memf(b + AW'(1)), memf(b)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk_in); #1;
        flush = 1'b0;
        model_clear();
        check_eq("flush_idle_ready", fetch_ready, 1);
    endtask

    // One fetch transaction. Knobs: flush with the request, flush on a given
    // accepted byte, a 3-cycle pause at a given byte, a reset at a given byte,
    // and random memory/pause timing. lat = edges from request to inst_valid.
    task automatic do_fetch(input logic [AW-1:0] a, input bit flush_req, input int flush_byte,
                            input int pause_byte, input int rst_byte, input bit rnd,
                            output int lat);
        int idx, tg, bytes, edges, pause_left;
        bit hit, cancel, take, pause_done;
        logic [AW-1:0] base, exp_addr;
        logic [31:0] exp_word;
        idx      = (int'(a) / NB) % NL;
        tg       = int'(a) / (NB * NL);
        hit      = mvalid[idx] && (mtag[idx] == tg) && !flush_req;
        exp_word = word_of(a);
        base     = a & ~(AW'(NB - 1));
        lat      = -1;

        fetch_req = 1'b1; fetch_addr = a; flush = flush_req; rdy_in = 1'b1; mem_valid = 1'b0;
        @(posedge clk_in); #1;
        fetch_req = 1'b0; flush = 1'b0; edges = 1;
        if (flush_req) model_clear();

        if (hit) begin
            check_eq("hit_valid", inst_valid, 1);
            check_eq("hit_data", inst_out, exp_word);
            check_eq("hit_no_mem_req", mem_req, 0);
            check_eq("hit_ready", fetch_ready, 1);
            lat = 1;
            return;
        end

        check_eq("miss_req", mem_req, 1);
        check_eq("miss_base", mem_addr, base);
        check_eq("miss_busy", fetch_ready, 0);
        check_eq("miss_no_valid", inst_valid, 0);

        bytes = 0; cancel = 0; pause_left = 0; pause_done = 0; exp_addr = base;
        while (bytes < NB && edges < 200) begin
            mem_data = memf(mem_addr);
            if (rst_byte == bytes) begin
                rst_in = 1'b0; mem_valid = 1'b1;
                @(posedge clk_in); #1;
                rst_in = 1'b1; mem_valid = 1'b0;
                check_eq("rst_mid_req", mem_req, 0);
                check_eq("rst_mid_ready", fetch_ready, 1);
                check_eq("rst_mid_valid", inst_valid, 0);
                check_eq("rst_mid_addr", mem_addr, 0);
                model_clear();
                lat = 0;
                return;
            end
            if (bytes == pause_byte && !pause_done) begin
                pause_left = 3; pause_done = 1;
            end
            if (pause_left > 0) begin
                rdy_in = 1'b0; mem_valid = 1'b1; pause_left--;
            end else begin
                rdy_in    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                mem_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            take = rdy_in && mem_valid && mem_req;
            if (take) begin
                check_eq("walk_addr", mem_addr, exp_addr);
                if (bytes == flush_byte) begin
                    flush = 1'b1; cancel = 1;
                end
            end
            @(posedge clk_in); #1;
            edges++;
            flush = 1'b0;
            if (take) begin
                bytes++; exp_addr = exp_addr + AW'(1);
            end
            check_eq("refill_no_valid", inst_valid, 0);
        end
        if (bytes < NB) begin
            check_eq("refill_timeout", bytes, NB);
            return;
        end
        check_eq("req_drop", mem_req, 0);
        mem_valid = 1'b0; rdy_in = 1'b1;
        if (cancel) model_clear();
        @(posedge clk_in); #1;
        edges++;
        check_eq("resp_valid", inst_valid, !cancel);
        if (!cancel) check_eq("resp_data", inst_out, exp_word);
        check_eq("resp_ready", fetch_ready, 1);
        if (!cancel) begin
            mvalid[idx] = 1'b1; mtag[idx] = tg;
        end
        lat = edges;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; fetch_req = 1'b0;
        fetch_addr = '0; mem_valid = 1'b0; mem_data = '0;
        model_clear();
        repeat (2) @(posedge clk_in);
        #1;
        check_eq("rst_valid", inst_valid, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_ready", fetch_ready, 1);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_inst_out", inst_out, 0);
        rst_in = 1'b1;
        @(posedge clk_in); #1;

        // Cold misses and the hit that follows
        do_fetch(17'h00000, 0, -1, -1, -1, 0, lat);
        do_fetch(17'h00104, 0, -1, -1, -1, 0, lat);
        check_eq("cold_lat", lat, 10);
        do_fetch(17'h00100, 0, -1, -1, -1, 0, lat);
        check_eq("hit_lat", lat, 1);
        check_eq("hit_word0", inst_out, 32'h03020100);

        // Conflict on index 0
        do_fetch(17'h00180, 0, -1, -1, -1, 0, lat);
        do_fetch(17'h00104, 0, -1, -1, -1, 0, lat);
        check_eq("conflict_refetch_lat", lat, 10);

        // Flush on the third accepted byte, then re-fetch misses
        do_fetch(17'h00208, 0, 2, -1, -1, 0, lat);
        do_fetch(17'h00208, 0, -1, -1, -1, 0, lat);
        check_eq("flush_refetch_lat", lat, 10);

        // Three pause cycles mid-refill
        do_fetch(17'h00310, 0, -1, 3, -1, 0, lat);
        check_eq("pause_lat", lat, 13);

        // Flush together with a request that would hit: treated as miss
        do_fetch(17'h00310, 1, -1, -1, -1, 0, lat);
        check_eq("flush_req_lat", lat, 10);
        do_fetch(17'h00314, 0, -1, -1, -1, 0, lat);
        check_eq("b2b_hit_word1", inst_out, 32'h17161514);
        do_fetch(17'h00310, 0, -1, -1, -1, 0, lat);
        do_fetch(17'h00314, 0, -1, -1, -1, 0, lat);
        check_eq("b2b_hit_lat", lat, 1);

        // Reset in the middle of a refill, then previously cached line misses
        do_fetch(17'h00400, 0, -1, -1, 4, 0, lat);
        do_fetch(17'h00310, 0, -1, -1, -1, 0, lat);
        check_eq("post_rst_miss_lat", lat, 10);

        // Randomized traffic against the model
        do_flush();
        hash_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] a;
            int fb;
            bit fr;
            a  = AW'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0) a = a | 17'h1FC00;
            fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
            fr = ($urandom_range(0, 15) == 0);
            do_fetch(a, fr, fb, -1, -1, 1, lat);
            if ($urandom_range(0, 24) == 0) do_flush();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
